mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter sitting directly below the instruction cache and the data cache. It takes miss/uncached requests from the instruction-cache memory port (i_*) and the data-cache memory port (d_*) and serialises them onto one main-memory port. Arbitration is round-robin, there is one outstanding transaction at a time, and a timeout watchdog guarantees that no requester hangs.

## Interface
- TIMEOUT, default 255: maximum number of REQ cycles to wait for mem_ready; 0 disables the watchdog; 8-bit value.
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- i_a  in  32  instruction-side address (driven by the cache's m_a).
- i_strobe  in  1  instruction-side request, level; held until i_ready.
- i_dout  out  32  read data returned to the instruction side.
- i_ready  out  1  one-cycle completion pulse to the instruction side.
- d_a  in  32  data-side address.
- d_din  in  32  data-side write data.
- d_rw  in  1  data-side direction; 1 = write, 0 = read.
- d_strobe  in  1  data-side request, level; held until d_ready.
- d_dout  out  32  read data returned to the data side.
- d_ready  out  1  one-cycle completion pulse to the data side.
- mem_a  out  32  memory address, registered.
- mem_din  out  32  memory write data, registered.
- mem_rw  out  1  memory direction, registered.
- mem_strobe  out  1  memory request, registered; held until mem_ready or timeout.
- mem_dout  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completion, one-cycle pulse.
- bus_err  out  1  sticky flag; set on timeout, cleared only by reset.

## Operation
- States: IDLE, REQ, RESP. Registers: owner (I or D), last_grant, timeout counter cnt (8 bits), return-data register rdata.
- IDLE:
  - If neither strobe is high, stay in IDLE.
  - If exactly one strobe is high, grant that side.
  - If both are high, grant the side that is not last_grant. last_grant resets to D, so the first tie goes to I.
  - On grant: latch the address (plus d_din and d_rw for D; mem_rw=0 for I) into mem_a/mem_din/mem_rw, set mem_strobe=1, set owner and last_grant, clear cnt, go to REQ.
- REQ:
  - mem_strobe and mem_a/mem_din/mem_rw stay constant.
  - On mem_ready: capture mem_dout into rdata, drop mem_strobe, go to RESP.
  - Otherwise cnt increments. When TIMEOUT≠0 and cnt reaches TIMEOUT-1 without mem_ready: drop mem_strobe, set rdata=0, set bus_err=1, go to RESP.
  - If mem_ready arrives in the same cycle as the timeout, mem_ready wins: no error, data is taken.
- RESP:
  - Pulse the owner's ready for exactly one cycle; the owner's dout = rdata. The non-owner's ready stays 0.
  - Go to IDLE unconditionally. A strobe seen in RESP is not granted in that cycle.
- Write transactions (d_rw=1): d_ready pulses in RESP; d_dout = rdata, which is don't-care for the cache.
- Abort: if the owner's strobe is low in the RESP cycle (pipeline flush), suppress that ready pulse. The memory transaction is never cancelled once granted.
- i_dout/d_dout hold their last value outside RESP.
- mem_ready while in IDLE or RESP is ignored.
- Requesters must hold address and data stable from strobe assertion until ready. The arbiter does not check this.

## Timing
- Reset values: state=IDLE, mem_strobe=0, mem_rw=0, mem_a=0, mem_din=0, i_ready=0, d_ready=0, i_dout=0, d_dout=0, bus_err=0, cnt=0, last_grant=D. Reset asserted mid-transaction returns everything to these values immediately; the memory request is abandoned.
- Cycle timeline:
  - Strobe seen in IDLE at cycle 0 gives mem_strobe=1 from cycle 1.
  - mem_ready in cycle k (k≥1) gives ready=1 in cycle k+1.
  - The arbiter is back in IDLE at cycle k+2.
- Minimum latency from strobe to ready is 2 cycles (memory answering in cycle 1).
- Back-to-back: a request pending during RESP is granted in the following IDLE cycle, so there is at least one idle cycle between memory transactions.
- Timeout: with no mem_ready, mem_strobe is high for exactly TIMEOUT cycles, then ready pulses in the next cycle.

## Test plan
- I-read alone: i_a=0x00000040, memory answers in cycle 1 with 0x8C010004 -> mem_strobe cycles 1-1, i_ready=1 in cycle 2 with i_dout=0x8C010004, d_ready stays 0.
- D-write: d_a=0x100, d_din=0xDEADBEEF, d_rw=1, memory latency 3 -> mem_rw=1 and mem_din=0xDEADBEEF held for 3 cycles, then d_ready pulses exactly once.
- Simultaneous i_strobe and d_strobe after reset -> I granted first; D granted in the IDLE cycle after I's RESP. A second tie after that is granted to D only if last_grant=I.
- Abort: i_strobe dropped while in REQ -> memory transaction still completes, no i_ready pulse, back in IDLE after RESP.
- Timeout with TIMEOUT=4 and memory never ready -> mem_strobe high for 4 cycles, ready pulses with dout=0, bus_err=1 and stays 1. Same-cycle mem_ready at the limit -> data returned, bus_err=0.
- clrn pulsed low during REQ -> all outputs return to reset values asynchronously, and a later request works normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
  logic [31:0] i_a;
  logic        i_strobe;
  logic [31:0] i_dout;
  logic        i_ready;
  logic [31:0] d_a;
  logic [31:0] d_din;
  logic        d_rw;
  logic        d_strobe;
  logic [31:0] d_dout;
  logic        d_ready;
  logic [31:0] mem_a;
  logic [31:0] mem_din;
  logic        mem_rw;
  logic        mem_strobe;
  logic [31:0] mem_dout;
  logic        mem_ready;
  logic        bus_err;

  modport slave (
    input  i_a, i_strobe, d_a, d_din, d_rw, d_strobe, mem_dout, mem_ready,
    output i_dout, i_ready, d_dout, d_ready, mem_a, mem_din, mem_rw, mem_strobe, bus_err
  );

  modport master (
    output i_a, i_strobe, d_a, d_din, d_rw, d_strobe, mem_dout, mem_ready,
    input  i_dout, i_ready, d_dout, d_ready, mem_a, mem_din, mem_rw, mem_strobe, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache misses onto one memory
// port, one transaction at a time, with a REQ-cycle timeout watchdog.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic         clk,
  input logic         clrn,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;          // 1 = D side
  logic        last_grant_reg, last_grant_next; // 1 = D side
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] i_dout_reg, i_dout_next;
  logic [31:0] d_dout_reg, d_dout_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [31:0] mem_din_reg, mem_din_next;
  logic        mem_rw_reg, mem_rw_next;
  logic        mem_strobe_reg, mem_strobe_next;
  logic        bus_err_reg, bus_err_next;
  logic        grant_d;
  logic        in_resp;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= 8'd0;
      rdata_reg      <= 32'd0;
      i_dout_reg     <= 32'd0;
      d_dout_reg     <= 32'd0;
      mem_a_reg      <= 32'd0;
      mem_din_reg    <= 32'd0;
      mem_rw_reg     <= 1'b0;
      mem_strobe_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      rdata_reg      <= rdata_next;
      i_dout_reg     <= i_dout_next;
      d_dout_reg     <= d_dout_next;
      mem_a_reg      <= mem_a_next;
      mem_din_reg    <= mem_din_next;
      mem_rw_reg     <= mem_rw_next;
      mem_strobe_reg <= mem_strobe_next;
      bus_err_reg    <= bus_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    rdata_next      = rdata_reg;
    i_dout_next     = i_dout_reg;
    d_dout_next     = d_dout_reg;
    mem_a_next      = mem_a_reg;
    mem_din_next    = mem_din_reg;
    mem_rw_next     = mem_rw_reg;
    mem_strobe_next = mem_strobe_reg;
    bus_err_next    = bus_err_reg;
    grant_d         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.i_strobe || bus.d_strobe) begin
          // On a tie the side that did not win last time gets the bus.
          grant_d         = bus.d_strobe && (!bus.i_strobe || !last_grant_reg);
          owner_next      = grant_d;
          last_grant_next = grant_d;
          cnt_next        = 8'd0;
          mem_strobe_next = 1'b1;
          state_next      = REQ;
          if (grant_d) begin
            mem_a_next   = bus.d_a;
            mem_din_next = bus.d_din;
            mem_rw_next  = bus.d_rw;
          end else begin
            mem_a_next  = bus.i_a;
            mem_rw_next = 1'b0;
          end
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          rdata_next      = bus.mem_dout;
          mem_strobe_next = 1'b0;
          state_next      = RESP;
        end else if ((TIMEOUT != 8'd0) && (cnt_reg == TIMEOUT - 8'd1)) begin
          rdata_next      = 32'd0;
          bus_err_next    = 1'b1;
          mem_strobe_next = 1'b0;
          state_next      = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        // Owner's dout keeps the returned word after the RESP cycle.
        if (owner_reg) d_dout_next = rdata_reg;
        else           i_dout_next = rdata_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_resp = (state_reg == RESP);

  // Ready is gated by the live strobe so a flushed request gets no pulse.
  assign bus.i_ready    = in_resp && !owner_reg && bus.i_strobe;
  assign bus.d_ready    = in_resp && owner_reg && bus.d_strobe;
  assign bus.i_dout     = (in_resp && !owner_reg) ? rdata_reg : i_dout_reg;
  assign bus.d_dout     = (in_resp && owner_reg) ? rdata_reg : d_dout_reg;
  assign bus.mem_a      = mem_a_reg;
  assign bus.mem_din    = mem_din_reg;
  assign bus.mem_rw     = mem_rw_reg;
  assign bus.mem_strobe = mem_strobe_reg;
  assign bus.bus_err    = bus_err_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a latency-programmable memory model plus a
// ready-pulse scoreboard fed by each scenario task.
module tb_mem_arbiter;
  logic clk;
  logic clrn;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct packed {
    logic        side;   // 1 = D
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          i_pulses = 0;
  int          d_pulses = 0;
  int          mem_lat = 1;
  bit          mem_never = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_img [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
    tick();
  endtask

  // Memory model: answers after mem_lat strobe cycles unless mem_never.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_dout  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      if (bus.mem_strobe) begin
        mem_cnt++;
        if (!mem_never && mem_cnt == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_dout  = mem_img.exists(bus.mem_a) ? mem_img[bus.mem_a] : 32'd0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard: every ready pulse must match the next expected completion.
  always @(negedge clk) begin
    if (clrn && (bus.i_ready || bus.d_ready)) begin
      exp_t e;
      exp_t got;
      if (bus.i_ready) i_pulses++;
      if (bus.d_ready) d_pulses++;
      got.side = bus.d_ready;
      got.data = bus.d_ready ? bus.d_dout : bus.i_dout;
      got.err  = bus.bus_err;
      checks++;
      if (bus.i_ready && bus.d_ready) begin
        errors++;
        $display("FAIL both_ready: got i_ready=1 d_ready=1, want only one");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got side=%0d data=%h, want no pulse", got.side, got.data);
      end else begin
        e = sb_q.pop_front();
        if (got !== e)
          begin
            errors++;
            $display("FAIL sb_txn: got side=%0d data=%h err=%0d, want side=%0d data=%h err=%0d",
                     got.side, got.data, got.err, e.side, e.data, e.err);
          end
        else
          $display("txn ok: side=%0d data=%h err=%0d", got.side, got.data, got.err);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({bus.mem_strobe, bus.mem_rw, bus.i_ready, bus.d_ready, bus.bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got strobe/rw/iready/dready/err=%b, want 00000",
               {bus.mem_strobe, bus.mem_rw, bus.i_ready, bus.d_ready, bus.bus_err});
    end
    checks++;
    if ({bus.mem_a, bus.mem_din, bus.i_dout, bus.d_dout} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got a=%h din=%h idout=%h ddout=%h, want all 0",
               bus.mem_a, bus.mem_din, bus.i_dout, bus.d_dout);
    end
  endtask

  task automatic test_i_read();
    mem_lat = 1;
    mem_img[32'h40] = 32'h8C01_0004;
    sb_q.push_back('{1'b0, 32'h8C01_0004, 1'b0});
    bus.i_a = 32'h40;
    bus.i_strobe = 1'b1;
    tick();  // cycle 1
    checks++;
    if (bus.mem_strobe !== 1'b1 || bus.mem_a !== 32'h40 || bus.mem_rw !== 1'b0) begin
      errors++;
      $display("FAIL iread_req: got strobe=%b a=%h rw=%b, want 1 00000040 0",
               bus.mem_strobe, bus.mem_a, bus.mem_rw);
    end
    tick();  // cycle 2
    checks++;
    if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.mem_strobe !== 1'b0) begin
      errors++;
      $display("FAIL iread_ready: got i_ready=%b d_ready=%b strobe=%b, want 1 0 0",
               bus.i_ready, bus.d_ready, bus.mem_strobe);
    end
    tick();  // cycle 3
    bus.i_strobe = 1'b0;
    checks++;
    if (bus.i_ready !== 1'b0 || bus.i_dout !== 32'h8C01_0004) begin
      errors++;
      $display("FAIL iread_hold: got i_ready=%b i_dout=%h, want 0 8c010004", bus.i_ready, bus.i_dout);
    end
    tick();
  endtask

  task automatic test_d_write();
    int pulses0;
    pulses0 = d_pulses;
    mem_lat = 3;
    mem_img[32'h100] = 32'h1234_5678;
    sb_q.push_back('{1'b1, 32'h1234_5678, 1'b0});
    bus.d_a = 32'h100;
    bus.d_din = 32'hDEAD_BEEF;
    bus.d_rw = 1'b1;
    bus.d_strobe = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.mem_strobe !== 1'b1 || bus.mem_rw !== 1'b1 || bus.mem_din !== 32'hDEAD_BEEF ||
          bus.mem_a !== 32'h100 || bus.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL dwrite_req c%0d: got strobe=%b rw=%b din=%h a=%h d_ready=%b, want 1 1 deadbeef 00000100 0",
                 c, bus.mem_strobe, bus.mem_rw, bus.mem_din, bus.mem_a, bus.d_ready);
      end
    end
    tick();  // cycle 4
    checks++;
    if (bus.d_ready !== 1'b1 || bus.mem_strobe !== 1'b0) begin
      errors++;
      $display("FAIL dwrite_ready: got d_ready=%b strobe=%b, want 1 0", bus.d_ready, bus.mem_strobe);
    end
    tick();  // cycle 5
    bus.d_strobe = 1'b0;
    bus.d_rw = 1'b0;
    tick();
    checks++;
    if (d_pulses - pulses0 !== 1) begin
      errors++;
      $display("FAIL dwrite_pulses: got %0d d_ready pulses, want 1", d_pulses - pulses0);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    mem_lat = 1;
    mem_img[32'h200] = 32'h2222_0001;
    mem_img[32'h300] = 32'h3333_0001;
    sb_q.push_back('{1'b0, 32'h2222_0001, 1'b0});
    sb_q.push_back('{1'b1, 32'h3333_0001, 1'b0});
    sb_q.push_back('{1'b0, 32'h2222_0001, 1'b0});
    sb_q.push_back('{1'b1, 32'h3333_0001, 1'b0});
    sb_q.push_back('{1'b0, 32'h2222_0001, 1'b0});
    bus.i_a = 32'h200;
    bus.d_a = 32'h300;
    bus.d_rw = 1'b0;
    bus.i_strobe = 1'b1;
    bus.d_strobe = 1'b1;
    tick();  // cycle 1: first tie after reset goes to I
    checks++;
    if (bus.mem_a !== 32'h200) begin
      errors++;
      $display("FAIL tie1_grant: got mem_a=%h, want 00000200", bus.mem_a);
    end
    tick();  // cycle 2: I RESP
    tick();  // cycle 3: idle gap, D pending
    bus.i_strobe = 1'b0;
    checks++;
    if (bus.mem_strobe !== 1'b0) begin
      errors++;
      $display("FAIL rr_gap: got mem_strobe=%b, want 0", bus.mem_strobe);
    end
    tick();  // cycle 4
    checks++;
    if (bus.mem_strobe !== 1'b1 || bus.mem_a !== 32'h300) begin
      errors++;
      $display("FAIL rr_dgrant: got strobe=%b mem_a=%h, want 1 00000300", bus.mem_strobe, bus.mem_a);
    end
    tick();  // cycle 5: D RESP
    tick();  // cycle 6: I alone so that last_grant becomes I
    bus.d_strobe = 1'b0;
    bus.i_strobe = 1'b1;
    tick();  // 7
    tick();  // 8: I RESP
    tick();  // 9: tie with last_grant=I
    bus.d_strobe = 1'b1;
    tick();  // 10
    checks++;
    if (bus.mem_a !== 32'h300) begin
      errors++;
      $display("FAIL tie2_grant: got mem_a=%h, want 00000300", bus.mem_a);
    end
    tick();  // 11: D RESP
    tick();  // 12
    bus.d_strobe = 1'b0;
    tick();  // 13
    checks++;
    if (bus.mem_a !== 32'h200) begin
      errors++;
      $display("FAIL rr_after: got mem_a=%h, want 00000200", bus.mem_a);
    end
    tick();  // 14: I RESP
    tick();
    bus.i_strobe = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int pulses0;
    pulses0 = i_pulses;
    mem_lat = 3;
    bus.i_a = 32'h40;
    bus.i_strobe = 1'b1;
    tick();  // 1
    tick();  // 2: flush
    bus.i_strobe = 1'b0;
    checks++;
    if (bus.mem_strobe !== 1'b1) begin
      errors++;
      $display("FAIL abort_held: got mem_strobe=%b, want 1", bus.mem_strobe);
    end
    tick();  // 3: memory answers
    tick();  // 4: RESP
    checks++;
    if (bus.i_ready !== 1'b0 || bus.mem_strobe !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got i_ready=%b strobe=%b, want 0 0", bus.i_ready, bus.mem_strobe);
    end
    tick();
    tick();
    checks++;
    if (i_pulses != pulses0 || bus.mem_strobe !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got %0d pulses strobe=%b, want 0 0", i_pulses - pulses0, bus.mem_strobe);
    end
  endtask

  task automatic test_timeout();
    mem_never = 1;
    sb_q.push_back('{1'b1, 32'h0, 1'b1});
    bus.d_a = 32'h500;
    bus.d_rw = 1'b0;
    bus.d_strobe = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (bus.mem_strobe !== 1'b1) begin
        errors++;
        $display("FAIL timeout_strobe c%0d: got %b, want 1", c, bus.mem_strobe);
      end
    end
    tick();  // 5
    checks++;
    if (bus.mem_strobe !== 1'b0 || bus.d_ready !== 1'b1 || bus.d_dout !== 32'd0 || bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_resp: got strobe=%b d_ready=%b d_dout=%h err=%b, want 0 1 0 1",
               bus.mem_strobe, bus.d_ready, bus.d_dout, bus.bus_err);
    end
    tick();
    bus.d_strobe = 1'b0;
    mem_never = 0;
    tick();
    tick();
    checks++;
    if (bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got bus_err=%b, want 1", bus.bus_err);
    end
  endtask

  task automatic test_timeout_tie();
    apply_reset();
    mem_lat = 4;
    mem_img[32'h600] = 32'hCAFE_F00D;
    sb_q.push_back('{1'b0, 32'hCAFE_F00D, 1'b0});
    bus.i_a = 32'h600;
    bus.i_strobe = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if (bus.i_ready !== 1'b1 || bus.i_dout !== 32'hCAFE_F00D || bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL tie_limit: got i_ready=%b i_dout=%h err=%b, want 1 cafef00d 0",
               bus.i_ready, bus.i_dout, bus.bus_err);
    end
    tick();
    bus.i_strobe = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_never = 1;
    bus.i_a = 32'h700;
    bus.i_strobe = 1'b1;
    tick();  // REQ
    #3;
    clrn = 1'b0;
    bus.i_strobe = 1'b0;
    #1;
    checks++;
    if ({bus.mem_strobe, bus.mem_rw, bus.i_ready, bus.bus_err} !== 4'b0 ||
        bus.mem_a !== 32'd0 || bus.i_dout !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got strobe=%b a=%h i_dout=%h, want 0 0 0",
               bus.mem_strobe, bus.mem_a, bus.i_dout);
    end
    tick();
    clrn = 1'b1;
    mem_never = 0;
    mem_lat = 1;
    tick();
    sb_q.push_back('{1'b0, 32'h8C01_0004, 1'b0});
    bus.i_a = 32'h40;
    bus.i_strobe = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_txn: got i_ready=%b, want 1", bus.i_ready);
    end
    tick();
    bus.i_strobe = 1'b0;
    tick();
  endtask

  initial begin
    clrn = 1'b0;
    bus.i_a = 32'd0;
    bus.i_strobe = 1'b0;
    bus.d_a = 32'd0;
    bus.d_din = 32'd0;
    bus.d_rw = 1'b0;
    bus.d_strobe = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
    tick();
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_abort();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending completions, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
